// File: rtl/ram_responder.sv
// Memory-side responder for the mobo RAM control interface: four-phase req/ack,
// programmable access latency, byte-masked writes against an internal word array.
module ram_responder #(
    parameter int          ADDR_BITS = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] ctrl_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    output logic [31:0] ctrl_out,
    output logic [31:0] rd_data
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic        ack;
    logic        err;
    logic        busy;

    logic        req;
    logic        we_p0;
    logic [3:0]  be_p0;
    logic [31:0] addr_p0;
    logic [31:0] data_p0;

    logic [31:0] mem [0:DEPTH-1];

    logic [31:0]          off;
    logic                 dec_err;
    logic [ADDR_BITS-1:0] idx;
    logic [31:0]          cur_word;
    logic [31:0]          merged;
    logic [31:0]          resp_word;
    logic                 last_busy;
    logic                 commit;
    logic                 unused_ctrl;

    function automatic logic [31:0] byte_merge(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] w;
        w = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) w[8*i +: 8] = new_word[8*i +: 8];
        end
        return w;
    endfunction

    assign req         = ctrl_in[0];
    assign unused_ctrl = ^ctrl_in[31:6];

    // Request capture: latched once in IDLE so later input changes are ignored
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            addr_p0 <= addr_in;
            data_p0 <= data_in;
            we_p0   <= ctrl_in[1];
            be_p0   <= ctrl_in[5:2];
        end
    end

    // Address decode and write merge, evaluated on the last BUSY cycle
    assign off       = addr_p0 - BASE_ADDR;
    assign dec_err   = (addr_p0 < BASE_ADDR) || (off[1:0] != 2'b00) ||
                       ({2'b00, off[31:2]} >= (32'd1 << ADDR_BITS));
    assign idx       = off[ADDR_BITS+1:2];
    assign cur_word  = mem[idx];
    assign merged    = byte_merge(cur_word, data_p0, be_p0);
    assign resp_word = we_p0 ? merged : cur_word;
    assign last_busy = (state == BUSY) && (cnt == 4'd0);
    assign commit    = last_busy && we_p0 && !dec_err;

    // Array storage is deliberately not reset; an aborted access never reaches commit
    always_ff @(posedge clk) begin
        if (commit) mem[idx] <= merged;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            ack     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b0;
            rd_data <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        state <= BUSY;
                        cnt   <= 4'(LATENCY);
                        busy  <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        state   <= RESP;
                        ack     <= 1'b1;
                        err     <= dec_err;
                        rd_data <= dec_err ? 32'd0 : resp_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (!req) begin
                        state   <= IDLE;
                        ack     <= 1'b0;
                        err     <= 1'b0;
                        busy    <= 1'b0;
                        rd_data <= 32'd0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ack   <= 1'b0;
                    err   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_out = {29'd0, busy, err, ack};

endmodule

// File: tb/tb_ram_responder.sv
// Randomized self-checking bench for ram_responder against a word-array model
// that applies the address/byte-enable rules with plain integer arithmetic.
module tb_ram_responder;

    localparam int          AB    = 6;
    localparam int          DEPTH = 1 << AB;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ctrl_in;
    logic [31:0] addr_in;
    logic [31:0] data_in;
    logic [31:0] ctrl_out;
    logic [31:0] rd_data;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mm [DEPTH];
    logic [31:0] seen;

    ram_responder #(.ADDR_BITS(AB), .BASE_ADDR(BASE), .LATENCY(LAT)) dut (
        .clk     (clk),
        .rst     (rst),
        .ctrl_in (ctrl_in),
        .addr_in (addr_in),
        .data_in (data_in),
        .ctrl_out(ctrl_out),
        .rd_data (rd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit model_err(input logic [31:0] a);
        longint la = a;
        longint lb = BASE;
        if (la < lb) return 1'b1;
        if ((la - lb) % 4 != 0) return 1'b1;
        if ((la - lb) / 4 >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_access(input bit we, input logic [3:0] be,
                                                 input logic [31:0] a, input logic [31:0] d);
        longint      i;
        logic [31:0] w;
        if (model_err(a)) return 32'd0;
        i = (longint'(a) - longint'(BASE)) / 4;
        w = mm[i];
        if (we) begin
            for (int k = 0; k < 4; k++)
                if (be[k]) w[8*k +: 8] = d[8*k +: 8];
            mm[i] = w;
        end
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: normal handshake, 1: req pulsed for one edge, 2: req held 5 extra cycles
    task automatic access(input bit we, input logic [3:0] be, input logic [31:0] a,
                          input logic [31:0] d, input int mode, output logic [31:0] got_rd);
        bit          exp_err;
        logic [31:0] exp_rd;
        int          n;
        bit          got;
        exp_err = model_err(a);
        exp_rd  = model_access(we, be, a, d);
        ctrl_in = {26'd0, be, we, 1'b1};
        addr_in = a;
        data_in = d;
        n = 0;
        got = 1'b0;
        while (!got && n < LAT + 6) begin
            tick();
            n++;
            if (mode == 1 && n == 1) ctrl_in[0] = 1'b0;
            if (ctrl_out[0]) got = 1'b1;
            else chk("busy_wait", {31'd0, ctrl_out[2]}, 32'd1);
        end
        chk("ack_latency", n, LAT + 2);
        chk("err", {31'd0, ctrl_out[1]}, {31'd0, exp_err});
        chk("busy_resp", {31'd0, ctrl_out[2]}, 32'd1);
        chk("rd_data", rd_data, exp_rd);
        got_rd = rd_data;
        if (mode == 1) begin
            tick();
            chk("pulse_ack_off", ctrl_out, 32'd0);
            chk("pulse_rd_off", rd_data, 32'd0);
        end else begin
            if (mode == 2) begin
                for (int k = 0; k < 5; k++) begin
                    tick();
                    chk("hold_ack", {31'd0, ctrl_out[0]}, 32'd1);
                    chk("hold_rd", rd_data, exp_rd);
                end
            end
            ctrl_in[0] = 1'b0;
            tick();
            chk("drop_ctrl", ctrl_out, 32'd0);
            chk("drop_rd", rd_data, 32'd0);
        end
    endtask

    initial begin
        logic [31:0] a;
        int          r;
        rst     = 1'b1;
        ctrl_in = 32'd0;
        addr_in = 32'd0;
        data_in = 32'd0;
        #1;
        chk("reset_ctrl", ctrl_out, 32'd0);
        chk("reset_rd", rd_data, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("idle_ctrl", ctrl_out, 32'd0);

        for (int i = 0; i < DEPTH; i++)
            access(1'b1, 4'hF, BASE + 32'(4 * i), $urandom, 0, seen);

        access(1'b1, 4'hF, BASE + 32'h10, 32'hDEADBEEF, 0, seen);
        access(1'b0, 4'hF, BASE + 32'h10, 32'h0, 0, seen);
        chk("t1_read", seen, 32'hDEADBEEF);

        access(1'b1, 4'hF, BASE + 32'h20, 32'h11223344, 0, seen);
        access(1'b1, 4'b0101, BASE + 32'h20, 32'hAABBCCDD, 0, seen);
        chk("t2_merge", seen, 32'h11BB33DD);
        access(1'b0, 4'h0, BASE + 32'h20, 32'h0, 0, seen);
        chk("t2_read", seen, 32'h11BB33DD);

        access(1'b0, 4'hF, BASE + 32'h2, 32'h0, 0, seen);
        access(1'b0, 4'hF, BASE + 32'(4 * DEPTH), 32'h0, 0, seen);
        access(1'b1, 4'hF, BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 0, seen);
        access(1'b1, 4'hF, BASE - 32'h4, 32'hFFFF_FFFF, 0, seen);
        access(1'b0, 4'hF, BASE, 32'h0, 0, seen);
        access(1'b0, 4'hF, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 0, seen);

        access(1'b1, 4'b0011, BASE + 32'h24, 32'hCAFE_F00D, 2, seen);
        access(1'b0, 4'hF, BASE + 32'h24, 32'h0, 0, seen);

        access(1'b1, 4'hF, BASE + 32'h28, 32'h0BAD_CAFE, 1, seen);
        access(1'b0, 4'hF, BASE + 32'h28, 32'h0, 0, seen);
        chk("t5_read", seen, 32'h0BAD_CAFE);

        access(1'b1, 4'h0, BASE + 32'h28, 32'h1234_5678, 0, seen);
        chk("be0_write", seen, 32'h0BAD_CAFE);

        access(1'b1, 4'hF, BASE + 32'h30, 32'h55AA_55AA, 0, seen);
        ctrl_in = {26'd0, 4'hF, 1'b1, 1'b1};
        addr_in = BASE + 32'h30;
        data_in = 32'h1234_5678;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_busy_ctrl", ctrl_out, 32'd0);
        chk("rst_busy_rd", rd_data, 32'd0);
        ctrl_in = 32'd0;
        tick();
        rst = 1'b0;
        tick();
        access(1'b0, 4'hF, BASE + 32'h30, 32'h0, 0, seen);
        chk("rst_word_kept", seen, 32'h55AA_55AA);

        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 9);
            if (r == 0)      a = BASE + 32'($urandom_range(0, 4 * DEPTH + 16));
            else if (r == 1) a = $urandom;
            else if (r == 2) a = BASE - 32'(4 * $urandom_range(1, 4));
            else             a = BASE + 32'(4 * $urandom_range(0, DEPTH - 1));
            access(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom,
                   int'($urandom_range(0, 2)), seen);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
